fetch_pc: RTL
=============

# fetch_pc

Instruction-fetch stage that owns the program counter. It consumes the 2-bit next-PC select produced by the branch/jump resolution logic and the matching target addresses. It issues word fetches to instruction memory over a req/ready handshake and presents one fetched instruction with its PC to decode. It also handles stall hold, redirect flush, and the discarding of in-flight fetches.

## Interface
- RESET_PC, 32'h0000_1000, first fetch address after reset
- NOP_INST, 32'h0000_0013, value driven on `inst` when not valid
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_src  in  2  00 sequential, 01 branch taken, 10 jump, 11 reserved (treated as 00)
- branch_target  in  32  target used when pc_src=01
- jump_target  in  32  target used when pc_src=10
- stall  in  1  decode cannot accept; hold the current instruction
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of the request
- imem_ready  in  1  memory accepts the request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req and imem_ready
- inst  out  32  instruction to decode
- inst_pc  out  32  PC of `inst`
- inst_valid  out  1  `inst`/`inst_pc` are meaningful

## Operation
- State machine: BOOT, FETCH, WAIT, KILL.
- BOOT: entered on reset; lasts 1 cycle; imem_req=0; moves to FETCH.
- FETCH: imem_req=1 when not (stall and inst_valid). On imem_ready: latch inst=imem_rdata, inst_pc=imem_addr, inst_valid=1, pc+=4, and stay in FETCH. Without imem_ready: move to WAIT.
- WAIT: imem_req stays 1 and imem_addr stays stable until imem_ready. A request is never retracted.
- Redirect: occurs when pc_src is 01 or 10 in any state other than BOOT.
  - pc ← selected target.
  - inst_valid ← 0 next cycle; flush overrides stall.
  - If a request is outstanding and not accepted this cycle, latch the target into pending_pc and go to KILL.
- KILL: keep the old request until imem_ready, then drop its data (no inst_valid). Next cycle, request pending_pc in FETCH.
- A second redirect while in KILL overwrites pending_pc.
- Stall with inst_valid=1: inst, inst_pc, inst_valid held. No new request is issued. A request already in WAIT completes, and its data is buffered in a 1-entry skid register, released when stall drops.
- Skid full and stall still high: no further requests.
- pc_src=11: treated as sequential.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst=NOP_INST, inst_valid=0, inst_pc=0, pc=RESET_PC, skid empty.
- First imem_req: cycle 1 after reset deasserts.
- Fetch latency: instruction visible the cycle after imem_ready. With zero-wait memory, throughput is 1 instruction per cycle.
- Redirect to target request:
  - 1 cycle if no request is outstanding.
  - Otherwise 1 cycle after the killed request's imem_ready.
- Reset mid-WAIT: abandon the request immediately and return to BOOT. Memory must tolerate this.
- Simultaneous redirect and imem_ready in FETCH: the returned data is dropped and the next request goes to the target. No KILL.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect target with bits[1:0]≠0 does not fetch. The stage raises output `misalign` (1 bit, reset 0) and holds it with inst_valid=0 until the next redirect or reset. Meanwhile imem_req=0.
- FETCH_MISALIGN_TRAP_EN undefined:
  - Targets are forced word-aligned by clearing bits[1:0].
  - The `misalign` port does not exist.

## Structure
- Shared package holds:
  - `pc_src` encodings: PC_SRC_SEQ, PC_SRC_BRN, PC_SRC_JMP.
  - fetch state enum.
  - NOP_INST constant.
- Sub-module `fetch_skid`: 1-entry instruction/PC holding buffer with full flag. All other logic is in fetch_pc.

## Test plan
- Reset, then zero-wait memory for 4 cycles → imem_addr 1000, 1004, 1008, 100C; inst_pc trails by 1 cycle; inst_valid=1 from cycle 2.
- pc_src=01, branch_target=2000, while in FETCH with imem_ready=1 → data dropped; next imem_addr=2000; inst_valid=0 for 1 cycle.
- Memory holds ready low for 3 cycles, with pc_src=10 and jump_target=3000 in WAIT → old data discarded on ready; the following request has addr=3000; no inst_valid for the killed fetch.
- stall=1 for 5 cycles while a request is pending → skid fills, inst held, no new req; stall drop → skid instruction appears next cycle with no loss or duplication.
- Fetch at FFFF_FFFC → next imem_addr=0000_0000.
- With FETCH_MISALIGN_TRAP_EN, branch_target=2002 → misalign=1, imem_req=0; a later jump to 4000 clears misalign and fetches 4000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - next-PC select encodings driven by branch/jump resolution
//   - fetch state enum
//   - NOP instruction presented to decode when no instruction is valid
//   - word_align helper used when misaligned redirect trapping is disabled
package fetch_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BRN = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction/PC pair that returns from
// memory while decode is stalled on a valid instruction.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : discard the held entry (redirect)
//   push_i       : capture inst_i/pc_i
//   pop_i        : release the held entry
//   inst_o, pc_o : held instruction and its PC
//   full_o       : entry is occupied
module fetch_skid (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        full_o
);

  logic        full_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end

    if (rst_i) begin
      inst_q <= '0;
      pc_q   <= '0;
    end else if (push_i) begin
      inst_q <= inst_i;
      pc_q   <= pc_i;
    end
  end

  assign inst_o = inst_q;
  assign pc_o   = pc_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch stage owning the program counter.
// Issues word fetches over a req/ready handshake, presents one instruction
// plus PC to decode, and handles stall hold, redirect flush and discarding
// of in-flight fetches.
//   clock, reset        : clock, synchronous active-high reset
//   pc_src              : 00 seq, 01 branch, 10 jump, 11 treated as seq
//   branch_target       : target when pc_src=01
//   jump_target         : target when pc_src=10
//   stall               : decode cannot accept this cycle
//   imem_req/imem_addr  : fetch request and its word address
//   imem_ready/rdata    : memory accept and returned instruction
//   inst/inst_pc        : instruction to decode and its PC
//   inst_valid          : inst/inst_pc meaningful
//   misalign            : (FETCH_MISALIGN_TRAP_EN only) misaligned redirect
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets instead of silently word-aligning them.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;        // address of the current/next request
  logic [31:0]  pend_q, pend_d;    // redirect target waiting behind a killed fetch
  logic         req_q, req_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         mis_d;

  logic         redirect;
  logic [31:0]  raw_target;
  logic [31:0]  target;
  logic         accept;
  logic         hold;
  logic         deliver;

  logic         skid_push, skid_pop, skid_flush, skid_full, skid_full_d;
  logic [31:0]  skid_inst, skid_pc;

  assign redirect   = (state_q != ST_BOOT) &&
                      ((pc_src == PC_SRC_BRN) || (pc_src == PC_SRC_JMP));
  assign raw_target = (pc_src == PC_SRC_BRN) ? branch_target : jump_target;
  assign accept     = req_q && imem_ready;
  assign hold       = stall && valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;
  assign target = raw_target;
  assign mis_d  = redirect ? (raw_target[1:0] != 2'b00) : mis_q;

  always_ff @(posedge clock) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign misalign = mis_q;
`else
  assign target = word_align(raw_target);
  assign mis_d  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    valid_d    = valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;
    deliver    = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (accept) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
          deliver = 1'b1;
        end else if (req_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_KILL: begin
        if (accept) begin
          state_d = ST_FETCH;
          pc_d    = pend_q;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (redirect) begin
      // Flush overrides stall; any returning data this cycle is dropped.
      skid_flush = 1'b1;
      valid_d    = 1'b0;
      deliver    = 1'b0;
      if (req_q && !imem_ready) begin
        // Request cannot be retracted: wait it out in KILL.
        state_d = ST_KILL;
        pend_d  = target;
      end else begin
        state_d = ST_FETCH;
        pc_d    = target;
      end
    end else if (deliver) begin
      if (hold) begin
        skid_push = 1'b1;
      end else begin
        inst_d    = imem_rdata;
        inst_pc_d = pc_q;
        valid_d   = 1'b1;
      end
    end else if (!stall) begin
      if (skid_full) begin
        skid_pop  = 1'b1;
        inst_d    = skid_inst;
        inst_pc_d = skid_pc;
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    skid_full_d = skid_push || (skid_full && !skid_pop && !skid_flush);

    // Request is registered; a full skid always blocks so it can never overflow.
    req_d = (state_d == ST_WAIT) || (state_d == ST_KILL) ||
            ((state_d == ST_FETCH) && !skid_full_d && !(stall && valid_d) && !mis_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      pend_q    <= RESET_PC;
      req_q     <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  fetch_skid u_skid (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (skid_flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .inst_i  (imem_rdata),
    .pc_i    (pc_q),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc),
    .full_o  (skid_full)
  );

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = valid_q ? inst_q : NOP_INST;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;

endmodule
